// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - clock-enable scheduler: stop / divided free-run / single-step
//
// Purpose
//   Generates a registered one-cycle cpu_en strobe that advances the multi-cycle CPU.
//   The CPU stays on clk; only its enable is scheduled here. Three modes:
//     stop        - no strobes
//     free-run    - one strobe every div_r clk cycles (programmable divider)
//     single-step - one strobe per rising edge of the (already debounced) step button
//
// Ports
//   clk        in   1      system clock, all state changes on posedge
//   rst        in   1      asynchronous active-high reset
//   mode       in   2      00 stop, 01 free-run, 10 single-step, 11 stop
//   step_btn   in   1      debounced step button level, synchronous to clk
//   div_load   in   1      load div_val into the divisor register this cycle
//   div_val    in   CNT_W  new divisor (0 is stored as 1)
//   cpu_en     out  1      registered one-cycle advance strobe
//   blink      out  1      heartbeat, toggles on every free-run tick
//   cycle_cnt  out  16     number of strobes issued, wraps FFFF->0000
//   state      out  2/3    FSM state: STOP=0, RUN=1, STEP_ARM=2, STEP_HOLD=3 (BRK=4)
//   brk_en     in   1      (STEP_BRK_EN only) enable cycle-count breakpoint
//   brk_val    in   16     (STEP_BRK_EN only) breakpoint strobe count
//   brk_hit    out  1      (STEP_BRK_EN only) high while parked in BRK
//
// Configuration macro
//   STEP_BRK_EN - adds the cycle-count breakpoint and the BRK state (state widens to 3 bits).

module cpu_step_ctrl #(
  parameter int              CNT_W       = 32,
  parameter logic [CNT_W-1:0] DIV_DEFAULT = CNT_W'(25_000_000)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             step_btn,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_val,
`ifdef STEP_BRK_EN
  input  logic             brk_en,
  input  logic [15:0]      brk_val,
  output logic             brk_hit,
  output logic [2:0]       state,
`else
  output logic [1:0]       state,
`endif
  output logic             cpu_en,
  output logic             blink,
  output logic [15:0]      cycle_cnt
);

`ifdef STEP_BRK_EN
  typedef enum logic [2:0] {
    ST_STOP = 3'b000,
    ST_RUN  = 3'b001,
    ST_ARM  = 3'b010,
    ST_HOLD = 3'b011,
    ST_BRK  = 3'b100
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_STOP = 2'b00,
    ST_RUN  = 2'b01,
    ST_ARM  = 2'b10,
    ST_HOLD = 2'b11
  } state_t;
`endif

  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  state_t           state_r;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_r;
  logic             btn_q;
  logic             tick;
  logic             step_fire;
  logic             btn_rise;
  logic             div_end;

  assign state    = state_r;
  assign btn_rise = step_btn & ~btn_q;
  // div_r is never 0, so div_r-1 cannot underflow.
  assign div_end  = (cnt == (div_r - CNT_W'(1)));

  // Next-state and event decode. A mode change always wins over a pending
  // tick or step edge; div_load suppresses the event in its cycle. Suppressed
  // events are simply lost.
  always_comb begin
    state_n   = state_r;
    tick      = 1'b0;
    step_fire = 1'b0;
    case (state_r)
      ST_STOP: begin
        if (mode == MODE_RUN)       state_n = ST_RUN;
        else if (mode == MODE_STEP) state_n = ST_ARM;
      end
      ST_RUN: begin
        if (mode == MODE_STEP)     state_n = ST_ARM;
        else if (mode != MODE_RUN) state_n = ST_STOP;
`ifdef STEP_BRK_EN
        // The strobe currently on cpu_en is the one that brings cycle_cnt to
        // brk_val; park after it and drop any tick coinciding with it.
        else if (brk_en && cpu_en && ((cycle_cnt + 16'd1) == brk_val)) state_n = ST_BRK;
`endif
        else if (!div_load && div_end) tick = 1'b1;
      end
      ST_ARM: begin
        if (mode == MODE_RUN)       state_n = ST_RUN;
        else if (mode != MODE_STEP) state_n = ST_STOP;
        else if (!div_load && btn_rise) begin
          step_fire = 1'b1;
          state_n   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Wait for release so a held button yields exactly one strobe.
        if (mode == MODE_RUN)       state_n = ST_RUN;
        else if (mode != MODE_STEP) state_n = ST_STOP;
        else if (!step_btn)         state_n = ST_ARM;
      end
`ifdef STEP_BRK_EN
      ST_BRK: begin
        if (mode == MODE_STEP)     state_n = ST_ARM;
        else if (mode != MODE_RUN) state_n = ST_STOP;
      end
`endif
      default: state_n = ST_STOP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_STOP;
    end else begin
      state_r <= state_n;
    end
  end

  // Divider: counts only while staying in RUN; cleared on a tick, on a
  // divisor load, and in every other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (div_load) begin
      cnt <= '0;
    end else if ((state_r == ST_RUN) && (state_n == ST_RUN) && !tick) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r <= DIV_DEFAULT;
    end else if (div_load) begin
      div_r <= (div_val == '0) ? CNT_W'(1) : div_val;
    end
  end

  // Edge detector history follows the button in every state so that entering
  // STEP_ARM with the button already down does not fire a stale step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= step_btn;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_en    <= 1'b0;
      blink     <= 1'b0;
      cycle_cnt <= 16'd0;
    end else begin
      cpu_en <= tick | step_fire;
      if (tick) begin
        blink <= ~blink;
      end
      // Counts the strobe present on cpu_en this cycle; wraps naturally.
      if (cpu_en) begin
        cycle_cnt <= cycle_cnt + 16'd1;
      end
    end
  end

`ifdef STEP_BRK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brk_hit <= 1'b0;
    end else begin
      brk_hit <= (state_n == ST_BRK);
    end
  end
`endif

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb/tb_cpu_step_ctrl.sv - directed self-checking bench for cpu_step_ctrl (DIV_DEFAULT=4)

module tb_cpu_step_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic        step_btn;
  logic        div_load;
  logic [31:0] div_val;
  logic        cpu_en;
  logic        blink;
  logic [15:0] cycle_cnt;
`ifdef STEP_BRK_EN
  logic        brk_en;
  logic [15:0] brk_val;
  logic        brk_hit;
  logic [2:0]  state;
`else
  logic [1:0]  state;
`endif

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;
  int strobes  = 0;

  cpu_step_ctrl #(
    .CNT_W       (32),
    .DIV_DEFAULT (32'd4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .step_btn  (step_btn),
    .div_load  (div_load),
    .div_val   (div_val),
`ifdef STEP_BRK_EN
    .brk_en    (brk_en),
    .brk_val   (brk_val),
    .brk_hit   (brk_hit),
`endif
    .state     (state),
    .cpu_en    (cpu_en),
    .blink     (blink),
    .cycle_cnt (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    mode     = 2'b00;
    step_btn = 1'b0;
    div_load = 1'b0;
    div_val  = 32'd0;
`ifdef STEP_BRK_EN
    brk_en   = 1'b0;
    brk_val  = 16'd0;
`endif
    step();
    step();
    chk("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("rst_blink", {31'd0, blink}, 32'd0);
    chk("rst_cycle_cnt", {16'd0, cycle_cnt}, 32'd0);
    chk("rst_state", 32'(state), 32'd0);

    // Free-run at divisor 4: strobes 4, 8, 12 cycles after RUN entry.
    rst  = 1'b0;
    mode = 2'b01;
    step();
    chk("run_entry_state", 32'(state), 32'd1);
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("run_cpu_en", {31'd0, cpu_en}, (i % 4 == 0) ? 32'd1 : 32'd0);
      chk("run_blink", {31'd0, blink}, 32'((i / 4) % 2));
      chk("run_cycle_cnt", {16'd0, cycle_cnt}, 32'((i - 1) / 4));
    end
    step();
    chk("run_cycle_cnt_3", {16'd0, cycle_cnt}, 32'd3);

    // Stop exactly on the tick cycle: tick dropped.
    step();
    step();
    mode = 2'b00;
    step();
    chk("stop_on_tick_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("stop_on_tick_state", 32'(state), 32'd0);
    chk("stop_on_tick_cycle_cnt", {16'd0, cycle_cnt}, 32'd3);
    chk("stop_on_tick_blink", {31'd0, blink}, 32'd1);
    step();
    step();
    chk("stop_idle_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("stop_idle_cycle_cnt", {16'd0, cycle_cnt}, 32'd3);

    // div_load of 0 while running: divisor becomes 1, strobe every cycle.
    mode = 2'b01;
    step();
    step();
    div_load = 1'b1;
    div_val  = 32'd0;
    step();
    div_load = 1'b0;
    chk("load_cycle_cpu_en", {31'd0, cpu_en}, 32'd0);
    for (int j = 1; j <= 5; j++) begin
      step();
      chk("div1_cpu_en", {31'd0, cpu_en}, 32'd1);
      chk("div1_cycle_cnt", {16'd0, cycle_cnt}, 32'(3 + j - 1));
    end

    // Drive cycle_cnt up to FFFF, then wrap.
    repeat (65528) step();
    chk("cnt_ffff", {16'd0, cycle_cnt}, 32'h0000_ffff);
    step();
    chk("cnt_wrap", {16'd0, cycle_cnt}, 32'd0);
    chk("cnt_wrap_cpu_en", {31'd0, cpu_en}, 32'd1);

    // Asynchronous reset in the middle of RUN.
    rst = 1'b1;
    #1;
    chk("async_rst_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("async_rst_blink", {31'd0, blink}, 32'd0);
    chk("async_rst_cycle_cnt", {16'd0, cycle_cnt}, 32'd0);
    chk("async_rst_state", 32'(state), 32'd0);
    step();

    // Single-step: two long presses give exactly two strobes.
    rst  = 1'b0;
    mode = 2'b10;
    step();
    chk("step_arm_state", 32'(state), 32'd2);
    for (int p = 0; p < 2; p++) begin
      step_btn = 1'b1;
      step();
      chk("step_press_cpu_en", {31'd0, cpu_en}, 32'd1);
      chk("step_press_state", 32'(state), 32'd3);
      strobes = 0;
      for (int h = 0; h < 19; h++) begin
        step();
        strobes += int'(cpu_en);
      end
      chk("step_hold_no_strobe", 32'(strobes), 32'd0);
      step_btn = 1'b0;
      step();
      chk("step_release_state", 32'(state), 32'd2);
    end
    chk("step_total_cycle_cnt", {16'd0, cycle_cnt}, 32'd2);

`ifdef STEP_BRK_EN
    rst = 1'b1;
    step();
    rst     = 1'b0;
    brk_en  = 1'b1;
    brk_val = 16'd3;
    mode    = 2'b01;
    strobes = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      strobes += int'(cpu_en);
    end
    chk("brk_strobes", 32'(strobes), 32'd3);
    chk("brk_hit", {31'd0, brk_hit}, 32'd1);
    chk("brk_state", 32'(state), 32'd4);
    chk("brk_cycle_cnt", {16'd0, cycle_cnt}, 32'd3);
    mode = 2'b00;
    step();
    chk("brk_exit_state", 32'(state), 32'd0);
    chk("brk_exit_hit", {31'd0, brk_hit}, 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
